seg7_num_display: RTL and testbench

- Multi-digit 7-segment driver. Takes a binary value, converts it to BCD sequentially (shift-add-3, one bit per cycle), and drives DIGITS active-low segment bytes.
- Adds what the single-digit decoder lacks: signed values, leading-zero blanking, minus sign, overflow indication, decimal points and a load/ready handshake.
- Sits between the control/datapath logic and the board HEX displays on DE0_TOP.

---
 rtl/seg7_num_display.sv | 264 ++++++++++++++++++++++++++
 tb/tb_seg7_num_display.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seg7_num_display.sv
`default_nettype none
// ============================================================================
// Module   : seg7_num_display
// Purpose  : Multi-digit 7-segment driver. A loaded binary value, optionally
//            two's complement, is converted to BCD with a sequential
//            shift-add-3 (one bit per cycle). The result is then composed into
//            active-low segment bytes with leading-zero blanking, a minus sign,
//            overflow dashes and per-digit decimal points.
// Ports    : iCLK    - system clock
//            iRST    - synchronous active-high reset
//            iLoad   - start strobe, sampled only while oReady=1
//            iValue  - value to display (DATA_W bits)
//            iSigned - treat iValue as two's complement (captured with iLoad)
//            iLzb    - leading-zero blanking enable (captured with iLoad)
//            iDp     - per-digit decimal point, active-high (captured)
//            iBlink  - blank the display on the blink phase (SEG7_BLINK_EN)
//            oReady  - high in IDLE only
//            oDone   - one-cycle pulse after oHEX has been updated
//            oOvf    - last loaded value did not fit the display
//            oHEX    - segments, active-low, digit k at [8k+7:8k], bit 7 = DP
// Options  : SEG7_BLINK_EN - adds BLINK_DIV parameter, iBlink input and a
//            free-running blink divider that masks oHEX.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_num_display #(
   parameter int DATA_W = 14,
   parameter int DIGITS = 4
`ifdef SEG7_BLINK_EN
   ,
   parameter int BLINK_DIV = 25000000
`endif
) (
   input  logic                  iCLK,
   input  logic                  iRST,
   input  logic                  iLoad,
   input  logic [DATA_W-1:0]     iValue,
   input  logic                  iSigned,
   input  logic                  iLzb,
   input  logic [DIGITS-1:0]     iDp,
`ifdef SEG7_BLINK_EN
   input  logic                  iBlink,
`endif
   output logic                  oReady,
   output logic                  oDone,
   output logic                  oOvf,
   output logic [8*DIGITS-1:0]   oHEX
);

   // 10^n as a 64-bit elaboration-time constant
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

   // Active-low segment pattern for a BCD nibble
   function automatic logic [7:0] seg7(input logic [3:0] n);
      logic [7:0] s;
      case (n)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   localparam int          CNT_W     = $clog2(DATA_W + 1);
   localparam int          BCD_W     = 4 * DIGITS;
   // Largest magnitude that fits; a negative value gives up one digit to the sign
   localparam logic [63:0] LIMIT_POS = pow10(DIGITS) - 64'd1;
   localparam logic [63:0] LIMIT_NEG = pow10(DIGITS - 1) - 64'd1;
   localparam logic [7:0]  SEG_BLANK = 8'hFF;
   localparam logic [7:0]  SEG_DASH  = 8'hBF;

   localparam logic [1:0]  ST_IDLE   = 2'd0;
   localparam logic [1:0]  ST_CONV   = 2'd1;
   localparam logic [1:0]  ST_DISP   = 2'd2;

   logic [1:0]          state_q, state_d;
   logic                ready, start, last_step;

   logic [CNT_W-1:0]    cnt_q;
   logic [DATA_W-1:0]   mag_q;
   logic [BCD_W-1:0]    bcd_q;
   logic                neg_q, ovf_q, lzb_q;
   logic [DIGITS-1:0]   dp_q;
   logic [8*DIGITS-1:0] hex_q, hex_d;
   logic                ovf_out_q, done_q;

   logic                neg_in;
   logic [DATA_W:0]     val_ext, mag_in;
   logic                ovf_in;

   logic [BCD_W-1:0]    bcd_adj, bcd_step;
   logic [DATA_W-1:0]   mag_step;

   int                  hi_digit;
   logic [7:0]          dig;

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (iLoad)     state_d = ST_CONV;
         ST_CONV: if (last_step) state_d = ST_DISP;
         ST_DISP:                state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      ready     = (state_q == ST_IDLE);
      start     = ready & iLoad;
      last_step = (state_q == ST_CONV) && (cnt_q == CNT_W'(1));
   end

   // ------------------------------------------------------------------------
   // Input capture: sign, magnitude (one extra bit so the most negative value
   // negates cleanly) and overflow decision against the constant limits.
   // ------------------------------------------------------------------------
   always_comb begin
      neg_in  = iSigned & iValue[DATA_W-1];
      val_ext = {neg_in, iValue};
      mag_in  = neg_in ? (~val_ext + (DATA_W+1)'(1)) : val_ext;
      ovf_in  = neg_in ? (64'(mag_in) > LIMIT_NEG) : (64'(mag_in) > LIMIT_POS);
   end

   // ------------------------------------------------------------------------
   // One shift-add-3 step: correct nibbles >= 5, then shift {bcd, mag} left.
   // Bits shifted past the top nibble are dropped (only happens on overflow).
   // ------------------------------------------------------------------------
   always_comb begin
      bcd_adj = bcd_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) begin
            bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
         end
      end
      bcd_step = {bcd_adj[BCD_W-2:0], mag_q[DATA_W-1]};
      mag_step = {mag_q[DATA_W-2:0], 1'b0};
   end

   // ------------------------------------------------------------------------
   // Display composition from the finished BCD value
   // ------------------------------------------------------------------------
   always_comb begin
      hi_digit = 0;
      for (int k = 0; k < DIGITS; k++) begin
         if (bcd_q[4*k +: 4] != 4'd0) begin
            hi_digit = k;
         end
      end

      hex_d = '1;
      dig   = SEG_BLANK;
      for (int k = 0; k < DIGITS; k++) begin
         dig = SEG_BLANK;
         if (ovf_q) begin
            dig = SEG_DASH;
         end else if (!lzb_q) begin
            // A non-overflowing negative value always has a zero top digit
            dig = (neg_q && (k == DIGITS - 1)) ? SEG_DASH : seg7(bcd_q[4*k +: 4]);
         end else if (k <= hi_digit) begin
            dig = seg7(bcd_q[4*k +: 4]);
         end else if (neg_q && (k == hi_digit + 1)) begin
            dig = SEG_DASH;
         end
         if (dp_q[k]) begin
            dig[7] = 1'b0;
         end
         hex_d[8*k +: 8] = dig;
      end
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         cnt_q     <= '0;
         mag_q     <= '0;
         bcd_q     <= '0;
         neg_q     <= 1'b0;
         ovf_q     <= 1'b0;
         lzb_q     <= 1'b0;
         dp_q      <= '0;
         hex_q     <= '1;
         ovf_out_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            neg_q <= neg_in;
            ovf_q <= ovf_in;
            lzb_q <= iLzb;
            dp_q  <= iDp;
            mag_q <= mag_in[DATA_W-1:0];
            bcd_q <= '0;
            cnt_q <= CNT_W'(DATA_W);
         end else if (state_q == ST_CONV) begin
            bcd_q <= bcd_step;
            mag_q <= mag_step;
            cnt_q <= cnt_q - CNT_W'(1);
         end else if (state_q == ST_DISP) begin
            hex_q     <= hex_d;
            ovf_out_q <= ovf_q;
            done_q    <= 1'b1;
         end
      end
   end

   assign oReady = ready;
   assign oDone  = done_q;
   assign oOvf   = ovf_out_q;

`ifdef SEG7_BLINK_EN
   // Free-running blink divider; masks the output only, never the register
   localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [BLK_W-1:0] blk_cnt_q;
   logic             blk_phase_q;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         blk_cnt_q   <= '0;
         blk_phase_q <= 1'b0;
      end else if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
         blk_cnt_q   <= '0;
         blk_phase_q <= ~blk_phase_q;
      end else begin
         blk_cnt_q   <= blk_cnt_q + BLK_W'(1);
      end
   end

   assign oHEX = (iBlink && blk_phase_q) ? '1 : hex_q;
`else
   assign oHEX = hex_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg7_num_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_num_display
// Purpose  : Directed self-checking bench for seg7_num_display (DATA_W=14,
//            DIGITS=4). Builds with or without SEG7_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_num_display;

   localparam int DATA_W = 14;
   localparam int DIGITS = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                iLoad;
   logic [DATA_W-1:0]   iValue;
   logic                iSigned;
   logic                iLzb;
   logic [DIGITS-1:0]   iDp;
   logic                oReady, oDone, oOvf;
   logic [8*DIGITS-1:0] oHEX;
`ifdef SEG7_BLINK_EN
   logic                iBlink;
`endif

   int                  n_assert = 0;
   int                  n_fail   = 0;
   logic [31:0]         disp_exp = 32'hFFFF_FFFF;

   always #5 clk = ~clk;

`ifdef SEG7_BLINK_EN
   seg7_num_display #(.DATA_W(DATA_W), .DIGITS(DIGITS), .BLINK_DIV(4)) dut (
`else
   seg7_num_display #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
`endif
      .iCLK    (clk),
      .iRST    (rst),
      .iLoad   (iLoad),
      .iValue  (iValue),
      .iSigned (iSigned),
      .iLzb    (iLzb),
      .iDp     (iDp),
`ifdef SEG7_BLINK_EN
      .iBlink  (iBlink),
`endif
      .oReady  (oReady),
      .oDone   (oDone),
      .oOvf    (oOvf),
      .oHEX    (oHEX)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full conversion with cycle-accurate handshake checks. reload_at>0 pulses
   // iLoad with value 5 at that edge while the conversion is busy.
   task automatic convert(input logic [DATA_W-1:0] v, input logic s, input logic lz,
                          input logic [DIGITS-1:0] dp, input logic [31:0] exp_hex,
                          input logic exp_ovf, input int reload_at);
      @(negedge clk);
      iValue = v; iSigned = s; iLzb = lz; iDp = dp; iLoad = 1'b1;
      @(posedge clk); #1;
      iLoad = 1'b0;
      chk("ready_low_after_load", 64'(oReady), 64'd0);
      for (int i = 1; i <= DATA_W; i++) begin
         @(posedge clk); #1;
         chk("ready_busy", 64'(oReady), 64'd0);
         chk("done_busy", 64'(oDone), 64'd0);
         chk("hex_hold", 64'(oHEX), 64'(disp_exp));
         if (i == reload_at - 1) begin
            iLoad = 1'b1; iValue = 14'd5;
         end
         if (i == reload_at) iLoad = 1'b0;
      end
      @(posedge clk); #1;
      chk("hex_result", 64'(oHEX), 64'(exp_hex));
      chk("ovf_result", 64'(oOvf), 64'(exp_ovf));
      chk("done_pulse", 64'(oDone), 64'd1);
      chk("ready_back", 64'(oReady), 64'd1);
      disp_exp = exp_hex;
      @(posedge clk); #1;
      chk("done_single", 64'(oDone), 64'd0);
   endtask

   initial begin
      rst = 1'b1; iLoad = 1'b0; iValue = '0; iSigned = 1'b0; iLzb = 1'b0; iDp = '0;
`ifdef SEG7_BLINK_EN
      iBlink = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hex", 64'(oHEX), 64'hFFFF_FFFF);
      chk("rst_ready", 64'(oReady), 64'd1);
      chk("rst_done", 64'(oDone), 64'd0);
      chk("rst_ovf", 64'(oOvf), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      convert(14'd1234, 1'b0, 1'b0, 4'b0000, 32'hF9A4_B099, 1'b0, 0);
      convert(14'h3FD6, 1'b1, 1'b1, 4'b0000, 32'hFFBF_99A4, 1'b0, 0);
      convert(14'h3FD6, 1'b1, 1'b0, 4'b0000, 32'hBFC0_99A4, 1'b0, 0);
      convert(14'd0,    1'b0, 1'b1, 4'b0001, 32'hFFFF_FF40, 1'b0, 0);
      convert(14'd10000,1'b0, 1'b0, 4'b0000, 32'hBFBF_BFBF, 1'b1, 0);
      convert(14'h3C18, 1'b1, 1'b0, 4'b0000, 32'hBFBF_BFBF, 1'b1, 0); // -1000
      convert(14'd9999, 1'b0, 1'b0, 4'b0000, 32'h9090_9090, 1'b0, 0);
      convert(14'h3C19, 1'b1, 1'b1, 4'b0000, 32'hBF90_9090, 1'b0, 0); // -999
      convert(14'h2000, 1'b1, 1'b1, 4'b0100, 32'hBF3F_BFBF, 1'b1, 0); // -8192, DP on digit2
      convert(14'h3FFF, 1'b0, 1'b1, 4'b0000, 32'hBFBF_BFBF, 1'b1, 0); // 16383 unsigned
      convert(14'd77,   1'b0, 1'b0, 4'b0000, 32'hC0C0_F8F8, 1'b0, 3); // reload ignored

      // Reset at E5 of a new conversion aborts it and blanks the display
      @(negedge clk);
      iValue = 14'd1234; iSigned = 1'b0; iLzb = 1'b0; iDp = '0; iLoad = 1'b1;
      @(posedge clk); #1;
      iLoad = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_hex", 64'(oHEX), 64'hFFFF_FFFF);
      chk("abort_ready", 64'(oReady), 64'd1);
      chk("abort_done", 64'(oDone), 64'd0);
      chk("abort_ovf", 64'(oOvf), 64'd0);
      rst = 1'b0;
      disp_exp = 32'hFFFF_FFFF;
      for (int i = 0; i < DATA_W + 3; i++) begin
         @(posedge clk); #1;
         chk("abort_no_done", 64'(oDone), 64'd0);
         chk("abort_blank", 64'(oHEX), 64'hFFFF_FFFF);
      end

      // DP on a blanked digit still shows
      convert(14'd5, 1'b0, 1'b1, 4'b1000, 32'h7FFF_FF92, 1'b0, 0);

`ifdef SEG7_BLINK_EN
      begin
         logic [15:0] blanked;
         int          nblank;
         iBlink = 1'b1;
         nblank = 0;
         for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            blanked[i] = (oHEX == 32'hFFFF_FFFF);
            if (blanked[i]) nblank++;
            else chk("blink_shown", 64'(oHEX), 64'(disp_exp));
         end
         chk("blink_count", 64'(nblank), 64'd8);
         for (int i = 4; i < 16; i++) begin
            chk("blink_period", 64'(blanked[i]), 64'(~blanked[i-4]));
         end
         iBlink = 1'b0;
         for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("blink_off_steady", 64'(oHEX), 64'(disp_exp));
         end
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
